dbg_mem_arbiter: RTL and testbench
==================================

Name: dbg_mem_arbiter

Overview:
- Shares the debug second ports of InstRAM and DataRAM (the CPU_Debug_*RAM_{A2,WD2,WE2,RD2} ports of the core) between two requesters: m0 (host debug link) and m1 (program loader / memory-dump engine).
- Round-robin grant, valid/ready request handshake, single-cycle response pulse.
- One outstanding transaction at a time; the block sits between the requesters and the core's debug memory ports.

Parameters:
RD_LAT, 1, clock edges from the address cycle to valid RD2 data; legal range 1..3.
ADDR_W, 32, debug address width.
DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
CPU_CLK  in  1  single clock; all state changes on rising edge.
CPU_RST  in  1  reset, asynchronous assert, active-low (0 = reset).
m0_req_valid / m1_req_valid  in  1  request present.
m0_req_ready / m1_req_ready  out  1  request accepted this cycle when valid also high.
m0_req_sel / m1_req_sel  in  1  target: 0 = DataRAM, 1 = InstRAM.
m0_req_addr / m1_req_addr  in  ADDR_W  byte address.
m0_req_wdata / m1_req_wdata  in  DATA_W  write data.
m0_req_we / m1_req_we  in  DATA_W/8  byte write enables; all-zero means read.
m0_resp_valid / m1_resp_valid  out  1  one-cycle response pulse.
m0_resp_rdata / m1_resp_rdata  out  DATA_W  read data; 0 for writes.
CPU_Debug_DataRAM_A2 / CPU_Debug_InstRAM_A2  out  ADDR_W  RAM port-2 address.
CPU_Debug_DataRAM_WD2 / CPU_Debug_InstRAM_WD2  out  DATA_W  RAM port-2 write data.
CPU_Debug_DataRAM_WE2 / CPU_Debug_InstRAM_WE2  out  DATA_W/8  RAM port-2 byte write enables.
CPU_Debug_DataRAM_RD2 / CPU_Debug_InstRAM_RD2  in  DATA_W  RAM port-2 read data.
busy  out  1  high in every state except IDLE.

Behaviour:
- **Reset values (async, CPU_RST=0):**
  - State IDLE; rr pointer = 0, so m0 has priority.
  - All A2, WD2 and WE2 outputs 0; busy=0; both resp_valid=0; both resp_rdata=0.
- **States:** IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- **IDLE:**
  - ready is combinational: only the granted master's ready may be high, and only in IDLE.
  - If exactly one valid is high, that master is granted.
  - If both are high, the master selected by rr is granted.
  - Handshake = valid & ready. On handshake, the block registers sel, addr, wdata, we and the master id, then moves to ACCESS.
- **ACCESS (exactly 1 cycle):**
  - The selected RAM's A2/WD2/WE2 are driven from the registered request.
  - The non-selected RAM's outputs stay 0.
  - WE2 is nonzero only in this cycle; a write never repeats.
- **WAIT (exactly RD_LAT cycles):**
  - A2 is held; WE2=0; a down-counter is loaded with RD_LAT-1.
  - On the last WAIT cycle, the selected RAM's RD2 is captured into the rdata register. For writes, 0 is captured instead.
- **RESP (1 cycle):**
  - The granted master's resp_valid=1 and resp_rdata is valid.
  - The other master's resp_valid=0.
  - rr toggles to point at the non-granted master. Return to IDLE.
- **Latency and throughput:**
  - Handshake edge to resp_valid is RD_LAT+2 cycles.
  - Next acceptance is possible in the cycle after RESP, so throughput is 1 transaction per RD_LAT+3 cycles.
- **Held outputs:** resp_rdata holds its value until the next capture; resp_valid never stays high longer than 1 cycle.
- **Unchanged fields:** address low bits pass through unmodified; the byte lanes are the RAM's concern.
- **Requester rules:** a master may drop valid before ready without penalty. A master must keep its request stable while valid and not ready; the arbiter does not check this.
- **Reset mid-transaction:** the transaction is abandoned, WE2 is forced to 0 immediately, and no response is issued.

Optional Feature:
DBG_MEM_ARB_PERF_EN
- **Defined:** adds outputs m0_grant_cnt and m1_grant_cnt, 16 bits each.
  - Each counter increments on its master's handshake and saturates at 16'hFFFF.
  - Both counters clear on reset.
  - Adds input perf_clr, a synchronous clear of both counters; clear wins over a same-cycle increment.
- **Undefined:** these ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- **m0 read:** RD_LAT=1. m0 reads DataRAM addr 0x10, RAM holds 0xDEADBEEF -> DataRAM_A2=0x10 in the ACCESS cycle, m0_resp_valid pulses 3 cycles after the handshake with rdata 0xDEADBEEF, InstRAM outputs stay 0.
- **m1 write:** m1 writes InstRAM addr 0x8 with wdata 0x00000013 and we=4'hF -> InstRAM_WE2=4'hF for exactly 1 cycle, m1_resp_valid=1 with rdata 0, busy low again on the next cycle.
- **Round-robin:** both valids held high for 4 transactions from reset -> grant order m0, m1, m0, m1; ready is never high for both masters in the same cycle.
- **Latency sweep:** RD_LAT=3 read -> resp_valid 5 cycles after the handshake, A2 held steady across all 3 WAIT cycles, and rdata equals RD2 sampled in the last WAIT cycle.
- **Async reset:** CPU_RST driven low during ACCESS of a write -> WE2=0 without waiting for a clock edge, no resp_valid ever issued, and after release m0 wins the first contended grant.
- **Perf counters (DBG_MEM_ARB_PERF_EN):** 3 m0 handshakes and 1 m1 handshake -> m0_grant_cnt=3, m1_grant_cnt=1; perf_clr pulse -> both counters 0.

Source files
------------

// File: rtl/dbg_mem_arbiter_if.sv
// dbg_mem_arbiter_if: one requester's valid/ready request channel and single-cycle response pulse.
interface dbg_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_sel;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_we;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;

    modport master (
        output req_valid, req_sel, req_addr, req_wdata, req_we,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_sel, req_addr, req_wdata, req_we,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter: round-robin sharing of the InstRAM/DataRAM debug port 2 between two requesters.
// Define DBG_MEM_ARB_PERF_EN to add saturating per-master grant counters with a synchronous perf_clr.
module dbg_mem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CPU_CLK,
    input  logic                  CPU_RST,
    dbg_mem_arbiter_if.slave      m0,
    dbg_mem_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0]     CPU_Debug_DataRAM_A2,
    output logic [DATA_W-1:0]     CPU_Debug_DataRAM_WD2,
    output logic [DATA_W/8-1:0]   CPU_Debug_DataRAM_WE2,
    input  logic [DATA_W-1:0]     CPU_Debug_DataRAM_RD2,
    output logic [ADDR_W-1:0]     CPU_Debug_InstRAM_A2,
    output logic [DATA_W-1:0]     CPU_Debug_InstRAM_WD2,
    output logic [DATA_W/8-1:0]   CPU_Debug_InstRAM_WE2,
    input  logic [DATA_W-1:0]     CPU_Debug_InstRAM_RD2,
    output logic                  busy
`ifdef DBG_MEM_ARB_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [15:0]           m0_grant_cnt,
    output logic [15:0]           m1_grant_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d, sel_q, sel_d, id_q, id_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0]   we_q, we_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  gnt, hs, acc, drv;

    // gnt=1 selects m1; rr only breaks ties when both masters are requesting
    assign gnt = m1.req_valid & (~m0.req_valid | rr_q);
    assign hs  = (state_q == IDLE) & (gnt ? m1.req_valid : m0.req_valid);

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            id_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (hs) begin
                state_d = ACCESS;
                id_d    = gnt;
                sel_d   = gnt ? m1.req_sel : m0.req_sel;
                addr_d  = gnt ? m1.req_addr : m0.req_addr;
                wdata_d = gnt ? m1.req_wdata : m0.req_wdata;
                we_d    = gnt ? m1.req_we : m0.req_we;
            end
            ACCESS: begin
                state_d = WAIT;
                cnt_d   = 2'(RD_LAT - 1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d = RESP;
                rdata_d = |we_q ? '0 : (sel_q ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2);
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = ~id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM outputs decode from the state register so an async reset drops WE2 at once
    always_comb begin
        acc                   = state_q == ACCESS;
        drv                   = acc | (state_q == WAIT);
        busy                  = state_q != IDLE;
        m0.req_ready          = (state_q == IDLE) & ~gnt;
        m1.req_ready          = (state_q == IDLE) & gnt;
        m0.resp_valid         = (state_q == RESP) & ~id_q;
        m1.resp_valid         = (state_q == RESP) & id_q;
        m0.resp_rdata         = rdata_q;
        m1.resp_rdata         = rdata_q;
        CPU_Debug_DataRAM_A2  = (drv & ~sel_q) ? addr_q : '0;
        CPU_Debug_DataRAM_WD2 = (acc & ~sel_q) ? wdata_q : '0;
        CPU_Debug_DataRAM_WE2 = (acc & ~sel_q) ? we_q : '0;
        CPU_Debug_InstRAM_A2  = (drv & sel_q) ? addr_q : '0;
        CPU_Debug_InstRAM_WD2 = (acc & sel_q) ? wdata_q : '0;
        CPU_Debug_InstRAM_WE2 = (acc & sel_q) ? we_q : '0;
    end

`ifdef DBG_MEM_ARB_PERF_EN
    logic [15:0] m0_grant_cnt_q, m0_grant_cnt_d, m1_grant_cnt_q, m1_grant_cnt_d;

    always_comb begin
        m0_grant_cnt_d = perf_clr ? '0 : m0_grant_cnt_q + 16'(hs & ~gnt & ~&m0_grant_cnt_q);
        m1_grant_cnt_d = perf_clr ? '0 : m1_grant_cnt_q + 16'(hs & gnt & ~&m1_grant_cnt_q);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            m0_grant_cnt_q <= '0;
            m1_grant_cnt_q <= '0;
        end else begin
            m0_grant_cnt_q <= m0_grant_cnt_d;
            m1_grant_cnt_q <= m1_grant_cnt_d;
        end
    end

    assign m0_grant_cnt = m0_grant_cnt_q;
    assign m1_grant_cnt = m1_grant_cnt_q;
`endif
endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// tb_dbg_mem_arbiter: directed scenarios plus randomized traffic against a transaction-timeline model.
// Two arbiters are built side by side: index 0 with RD_LAT=1, index 1 with RD_LAT=3.
module tb_dbg_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][1:0]       vld, sel;
    logic [1:0][1:0][31:0] addr, wdata;
    logic [1:0][1:0][3:0]  we;
    logic [1:0][31:0]      drd, ird;
    wire  [1:0][1:0]       rdy, rv;
    wire  [1:0][1:0][31:0] rdat;
    wire  [1:0][31:0]      da2, ia2, dwd, iwd;
    wire  [1:0][3:0]       dwe, iwe;
    wire  [1:0]            bsy;
`ifdef DBG_MEM_ARB_PERF_EN
    logic                  perf_clr;
    wire  [1:0][1:0][15:0] gcnt;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
        dbg_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
        assign m0.req_valid = vld[g][0];
        assign m0.req_sel   = sel[g][0];
        assign m0.req_addr  = addr[g][0];
        assign m0.req_wdata = wdata[g][0];
        assign m0.req_we    = we[g][0];
        assign m1.req_valid = vld[g][1];
        assign m1.req_sel   = sel[g][1];
        assign m1.req_addr  = addr[g][1];
        assign m1.req_wdata = wdata[g][1];
        assign m1.req_we    = we[g][1];
        assign rdy[g]  = {m1.req_ready, m0.req_ready};
        assign rv[g]   = {m1.resp_valid, m0.resp_valid};
        assign rdat[g] = {m1.resp_rdata, m0.resp_rdata};
        dbg_mem_arbiter #(.RD_LAT(g == 0 ? 1 : 3), .ADDR_W(32), .DATA_W(32)) dut (
            .CPU_CLK(clk),
            .CPU_RST(rst_n),
            .m0(m0),
            .m1(m1),
            .CPU_Debug_DataRAM_A2(da2[g]),
            .CPU_Debug_DataRAM_WD2(dwd[g]),
            .CPU_Debug_DataRAM_WE2(dwe[g]),
            .CPU_Debug_DataRAM_RD2(drd[g]),
            .CPU_Debug_InstRAM_A2(ia2[g]),
            .CPU_Debug_InstRAM_WD2(iwd[g]),
            .CPU_Debug_InstRAM_WE2(iwe[g]),
            .CPU_Debug_InstRAM_RD2(ird[g]),
            .busy(bsy[g])
`ifdef DBG_MEM_ARB_PERF_EN
            ,
            .perf_clr(perf_clr),
            .m0_grant_cnt(gcnt[g][0]),
            .m1_grant_cnt(gcnt[g][1])
`endif
        );
    end

    task automatic do_reset();
        vld = '0;
        sel = '0;
        addr = '0;
        wdata = '0;
        we = '0;
`ifdef DBG_MEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = '1;
        sel = '0;
        addr = {4{32'hA5A5_0004}};
        wdata = '1;
        we = '1;
        drd = {32'h1111_2222, 32'h3333_4444};
        ird = {32'h5555_6666, 32'h7777_8888};
`ifdef DBG_MEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({bsy[k], rv[k], rdat[k]} !== '0) begin
                failures++;
                $display("FAIL reset_resp dut%0d busy=%b rv=%b rdata=%h exp all 0", k, bsy[k], rv[k], rdat[k]);
            end
            checks++;
            if ({da2[k], dwd[k], dwe[k], ia2[k], iwd[k], iwe[k]} !== '0) begin
                failures++;
                $display("FAIL reset_ram dut%0d da2=%h dwe=%h ia2=%h iwe=%h exp all 0", k, da2[k], dwe[k], ia2[k], iwe[k]);
            end
            checks++;
            if (rdy[k] !== 2'b01) begin
                failures++;
                $display("FAIL reset_prio dut%0d ready=%b exp=01", k, rdy[k]);
            end
        end
    endtask

    task automatic test_m0_read();
        do_reset();
        drd[0] = 32'hDEADBEEF;
        ird[0] = 32'h1234_5678;
        @(posedge clk); #1;
        vld[0][0] = 1'b1;
        sel[0][0] = 1'b0;
        addr[0][0] = 32'h10;
        we[0][0] = 4'h0;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 2'b01) begin
            failures++;
            $display("FAIL m0_read_ready got=%b exp=01", rdy[0]);
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1 vld[0][0] = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (da2[0] !== 32'h10 || dwe[0] !== 4'h0 || {ia2[0], iwd[0], iwe[0]} !== '0) begin
                    failures++;
                    $display("FAIL m0_read_access da2=%h dwe=%h ia2=%h iwe=%h exp da2=10 rest 0", da2[0], dwe[0], ia2[0], iwe[0]);
                end
            end
            checks++;
            if (rv[0] !== (c == 3 ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL m0_read_resp_valid cycle=%0d got=%b exp=%b", c, rv[0], (c == 3 ? 2'b01 : 2'b00));
            end
            if (c == 3) begin
                checks++;
                if (rdat[0][0] !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL m0_read_rdata got=%h exp=deadbeef", rdat[0][0]);
                end
            end
        end
    endtask

    task automatic test_m1_write();
        do_reset();
        drd[0] = 32'hFFFF_FFFF;
        ird[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        vld[0][1] = 1'b1;
        sel[0][1] = 1'b1;
        addr[0][1] = 32'h8;
        wdata[0][1] = 32'h0000_0013;
        we[0][1] = 4'hF;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 2'b10) begin
            failures++;
            $display("FAIL m1_write_ready got=%b exp=10", rdy[0]);
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1 vld[0][1] = 1'b0;
            @(negedge clk);
            checks++;
            if (iwe[0] !== (c == 1 ? 4'hF : 4'h0) || dwe[0] !== 4'h0) begin
                failures++;
                $display("FAIL m1_write_we cycle=%0d iwe=%h dwe=%h exp iwe=%h dwe=0", c, iwe[0], dwe[0], (c == 1 ? 4'hF : 4'h0));
            end
            if (c == 1) begin
                checks++;
                if (ia2[0] !== 32'h8 || iwd[0] !== 32'h13 || da2[0] !== '0) begin
                    failures++;
                    $display("FAIL m1_write_access ia2=%h iwd=%h da2=%h exp 8/13/0", ia2[0], iwd[0], da2[0]);
                end
            end
            checks++;
            if (bsy[0] !== (c <= 3)) begin
                failures++;
                $display("FAIL m1_write_busy cycle=%0d got=%b exp=%b", c, bsy[0], (c <= 3));
            end
            checks++;
            if (rv[0] !== (c == 3 ? 2'b10 : 2'b00) || (c == 3 && rdat[0][1] !== '0)) begin
                failures++;
                $display("FAIL m1_write_resp cycle=%0d rv=%b rdata=%h exp rv=%b rdata=0", c, rv[0], rdat[0][1], (c == 3 ? 2'b10 : 2'b00));
            end
        end
    endtask

    task automatic test_round_robin();
        int ord[4] = '{default: -1};
        int n = 0;
        do_reset();
        vld[0] = 2'b11;
        sel[0] = 2'b00;
        we[0] = '0;
        addr[0][0] = 32'h100;
        addr[0][1] = 32'h200;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] === 2'b11) begin
                failures++;
                $display("FAIL rr_both_ready cycle=%0d got=%b exp one-hot or 00", c, rdy[0]);
            end
            if (rdy[0][0]) begin
                ord[n] = 0;
                n++;
            end else if (rdy[0][1]) begin
                ord[n] = 1;
                n++;
            end
            @(posedge clk); #1;
        end
        vld[0] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ord[i] != i % 2) begin
                failures++;
                $display("FAIL rr_order grant%0d got=%0d exp=%0d", i, ord[i], i % 2);
            end
        end
    endtask

    task automatic test_latency_sweep();
        logic [31:0] a, cap;
        cap = '0;
        do_reset();
        a = $urandom;
        @(posedge clk); #1;
        vld[1][0] = 1'b1;
        sel[1][0] = 1'b0;
        addr[1][0] = a;
        we[1][0] = 4'h0;
        drd[1] = $urandom;
        @(negedge clk);
        checks++;
        if (rdy[1] !== 2'b01) begin
            failures++;
            $display("FAIL lat3_ready got=%b exp=01", rdy[1]);
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            vld[1][0] = 1'b0;
            drd[1] = $urandom;
            ird[1] = $urandom;
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (da2[1] !== a || dwe[1] !== 4'h0 || ia2[1] !== '0) begin
                    failures++;
                    $display("FAIL lat3_addr_hold cycle=%0d da2=%h dwe=%h ia2=%h exp da2=%h", c, da2[1], dwe[1], ia2[1], a);
                end
            end
            if (c == 4) cap = drd[1];
            checks++;
            if (rv[1] !== (c == 5 ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL lat3_resp_valid cycle=%0d got=%b exp=%b", c, rv[1], (c == 5 ? 2'b01 : 2'b00));
            end
            if (c == 5) begin
                checks++;
                if (rdat[1][0] !== cap) begin
                    failures++;
                    $display("FAIL lat3_rdata got=%h exp=%h", rdat[1][0], cap);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(posedge clk); #1;
        vld[0][0] = 1'b1;
        sel[0][0] = 1'b0;
        addr[0][0] = 32'h20;
        we[0][0] = 4'h0;
        @(posedge clk); #1 vld[0][0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vld[0][1] = 1'b1;
        sel[0][1] = 1'b1;
        addr[0][1] = 32'h40;
        wdata[0][1] = $urandom;
        we[0][1] = 4'hF;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 2'b10) begin
            failures++;
            $display("FAIL arst_m1_ready got=%b exp=10", rdy[0]);
        end
        @(posedge clk); #1 vld[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (iwe[0] !== 4'hF) begin
            failures++;
            $display("FAIL arst_pre_we got=%h exp=f", iwe[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (iwe[0] !== 4'h0 || ia2[0] !== '0 || bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL arst_we_drop iwe=%h ia2=%h busy=%b exp 0/0/0", iwe[0], ia2[0], bsy[0]);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rv[0] !== 2'b00) begin
                failures++;
                $display("FAIL arst_no_resp cycle=%0d got=%b exp=00", c, rv[0]);
            end
            @(posedge clk); #1;
        end
        vld[0] = 2'b11;
        we[0] = '0;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 2'b01) begin
            failures++;
            $display("FAIL arst_first_grant got=%b exp=01", rdy[0]);
        end
        @(posedge clk); #1 vld[0] = 2'b00;
    endtask

`ifdef DBG_MEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (gcnt[0] !== '0) begin
            failures++;
            $display("FAIL perf_reset m0=%0d m1=%0d exp 0/0", gcnt[0][0], gcnt[0][1]);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 vld[0][i == 3] = 1'b1;
            @(posedge clk); #1 vld[0][i == 3] = 1'b0;
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (gcnt[0][0] !== 16'd3 || gcnt[0][1] !== 16'd1) begin
            failures++;
            $display("FAIL perf_count m0=%0d m1=%0d exp 3/1", gcnt[0][0], gcnt[0][1]);
        end
        @(posedge clk); #1 perf_clr = 1'b1;
        @(posedge clk); #1 perf_clr = 1'b0;
        checks++;
        if (gcnt[0] !== '0) begin
            failures++;
            $display("FAIL perf_clear m0=%0d m1=%0d exp 0/0", gcnt[0][0], gcnt[0][1]);
        end
        vld[0][0] = 1'b1;
        @(posedge clk); #1 vld[0][0] = 1'b0;
        @(posedge clk); #1 perf_clr = 1'b1;
        vld[0][0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 perf_clr = 1'b0;
        vld[0][1] = 1'b1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        vld[0][1] = 1'b0;
        perf_clr = 1'b0;
        checks++;
        if (gcnt[0] !== '0) begin
            failures++;
            $display("FAIL perf_clr_wins m0=%0d m1=%0d exp 0/0", gcnt[0][0], gcnt[0][1]);
        end
    endtask
`endif

    task automatic test_random(input int k, input int n);
        int lat, free_t, hs_t, ph;
        bit rr, g, idle, act, t_sel, t_id;
        logic [31:0] t_addr, t_wd, exp_rd;
        logic [3:0] t_we;
        logic [1:0] exp_rdy, exp_rv;
        lat = (k == 0) ? 1 : 3;
        do_reset();
        rr = 1'b0;
        free_t = 0;
        hs_t = -100;
        exp_rd = '0;
        t_sel = 1'b0;
        t_id = 1'b0;
        t_addr = '0;
        t_wd = '0;
        t_we = '0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 2; j++) begin
                vld[k][j] = $urandom_range(0, 2) != 0;
                sel[k][j] = 1'($urandom);
                addr[k][j] = $urandom;
                wdata[k][j] = $urandom;
                we[k][j] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            end
            drd[k] = $urandom;
            ird[k] = $urandom;
            @(negedge clk);
            idle = t >= free_t;
            g = vld[k][1] && (!vld[k][0] || rr);
            exp_rdy = idle ? (g ? 2'b10 : 2'b01) : 2'b00;
            ph = t - hs_t;
            act = ph >= 1 && ph <= lat + 1;
            exp_rv = (ph == lat + 2) ? (t_id ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (rdy[k] !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready dut%0d t=%0d got=%b exp=%b", k, t, rdy[k], exp_rdy);
            end
            checks++;
            if (bsy[k] !== (ph >= 1 && ph <= lat + 2)) begin
                failures++;
                $display("FAIL rand_busy dut%0d t=%0d got=%b exp=%b", k, t, bsy[k], (ph >= 1 && ph <= lat + 2));
            end
            checks++;
            if (rv[k] !== exp_rv || rdat[k] !== {exp_rd, exp_rd}) begin
                failures++;
                $display("FAIL rand_resp dut%0d t=%0d rv=%b rdata=%h exp rv=%b rdata=%h", k, t, rv[k], rdat[k], exp_rv, exp_rd);
            end
            checks++;
            if (da2[k] !== ((act && !t_sel) ? t_addr : 32'h0) || dwd[k] !== ((ph == 1 && !t_sel) ? t_wd : 32'h0) ||
                dwe[k] !== ((ph == 1 && !t_sel) ? t_we : 4'h0)) begin
                failures++;
                $display("FAIL rand_dram dut%0d t=%0d a2=%h wd2=%h we2=%h exp a2=%h", k, t, da2[k], dwd[k], dwe[k], (act && !t_sel) ? t_addr : 32'h0);
            end
            checks++;
            if (ia2[k] !== ((act && t_sel) ? t_addr : 32'h0) || iwd[k] !== ((ph == 1 && t_sel) ? t_wd : 32'h0) ||
                iwe[k] !== ((ph == 1 && t_sel) ? t_we : 4'h0)) begin
                failures++;
                $display("FAIL rand_iram dut%0d t=%0d a2=%h wd2=%h we2=%h exp a2=%h", k, t, ia2[k], iwd[k], iwe[k], (act && t_sel) ? t_addr : 32'h0);
            end
            if (ph == lat + 1) exp_rd = (t_we != 4'h0) ? 32'h0 : (t_sel ? ird[k] : drd[k]);
            if (idle && (g ? vld[k][1] : vld[k][0])) begin
                hs_t = t;
                free_t = t + lat + 3;
                t_id = g;
                t_sel = sel[k][g];
                t_addr = addr[k][g];
                t_wd = wdata[k][g];
                t_we = we[k][g];
                rr = !g;
            end
        end
        vld[k] = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin();
        test_latency_sweep();
        test_async_reset();
`ifdef DBG_MEM_ARB_PERF_EN
        test_perf();
`endif
        test_random(0, 400);
        test_random(1, 400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
